// File: rtl/mont_exp_sequencer.sv
// Left-to-right square-and-multiply exponentiation driving one shared Montgomery
// multiplier: x^e mod M, with Montgomery domain entry (x*R^2) and exit (*1).
module mont_exp_sequencer #(
    parameter int W  = 1024,
    parameter int LW = 11
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          start,
    input  logic [W-1:0]  in_x,
    input  logic [W-1:0]  in_e,
    input  logic [LW-1:0] in_elen,
    input  logic [W-1:0]  in_m,
    input  logic [W-1:0]  in_r,
    input  logic [W-1:0]  in_r2,
    output logic          busy,
    output logic          done,
    output logic [W-1:0]  result,
    output logic          mul_start,
    output logic [W-1:0]  mul_a,
    output logic [W-1:0]  mul_b,
    output logic [W-1:0]  mul_m,
    input  logic [W-1:0]  mul_result,
    input  logic          mul_done
);

    typedef enum logic [3:0] {
        IDLE, TOM_I, TOM_W, SQ_I, SQ_W, MUL_I, MUL_W, FROM_I, FROM_W, DONE
    } state_t;

    localparam logic [LW-1:0] W_L = LW'(W);

    state_t        state, state_nx;
    logic [W-1:0]  acc;
    logic [W-1:0]  xt;
    logic [W-1:0]  e_sh;
    logic [LW-1:0] cnt;
    logic          pend;
    logic [LW-1:0] elen_sat;

    assign elen_sat = (in_elen > W_L) ? W_L : in_elen;
    assign mul_m    = in_m;
    assign busy     = (state != IDLE);
    assign done     = (state == DONE);

    always_comb begin
        state_nx  = state;
        mul_start = 1'b0;
        case (state)
            IDLE:   if (start) state_nx = TOM_I;
            TOM_I: begin
                mul_start = 1'b1;
                state_nx  = TOM_W;
            end
            TOM_W:  if (mul_done) state_nx = (cnt == '0) ? FROM_I : SQ_I;
            SQ_I: begin
                mul_start = 1'b1;
                state_nx  = SQ_W;
            end
            SQ_W: begin
                if (mul_done) begin
                    if (e_sh[W-1])              state_nx = MUL_I;
                    else if (cnt == LW'(1))     state_nx = FROM_I;
                    else                        state_nx = SQ_I;
                end
            end
            // pend is always set on entry; the fallback only guards against a lost bit
            MUL_I: begin
                mul_start = pend;
                if (pend) state_nx = MUL_W;
                else      state_nx = (cnt == '0) ? FROM_I : SQ_I;
            end
            MUL_W:  if (mul_done) state_nx = (cnt == '0) ? FROM_I : SQ_I;
            FROM_I: begin
                mul_start = 1'b1;
                state_nx  = FROM_W;
            end
            FROM_W: if (mul_done) state_nx = DONE;
            DONE:   state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Operands depend on state only, so they hold through each issue/wait pair.
    always_comb begin
        mul_a = '0;
        mul_b = '0;
        case (state)
            TOM_I, TOM_W: begin
                mul_a = in_x;
                mul_b = in_r2;
            end
            SQ_I, SQ_W: begin
                mul_a = acc;
                mul_b = acc;
            end
            MUL_I, MUL_W: begin
                mul_a = acc;
                mul_b = xt;
            end
            FROM_I, FROM_W: begin
                mul_a = acc;
                mul_b = W'(1);
            end
            default: ;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state  <= IDLE;
            acc    <= '0;
            xt     <= '0;
            e_sh   <= '0;
            cnt    <= '0;
            pend   <= 1'b0;
            result <= '0;
        end else begin
            state <= state_nx;
            case (state)
                IDLE: begin
                    if (start) begin
                        acc  <= in_r;
                        e_sh <= in_e << (W_L - elen_sat);
                        cnt  <= elen_sat;
                        pend <= 1'b0;
                    end
                end
                TOM_W: if (mul_done) xt <= mul_result;
                SQ_W: begin
                    if (mul_done) begin
                        acc  <= mul_result;
                        pend <= e_sh[W-1];
                        e_sh <= e_sh << 1;
                        cnt  <= cnt - LW'(1);
                    end
                end
                MUL_W: begin
                    if (mul_done) begin
                        acc  <= mul_result;
                        pend <= 1'b0;
                    end
                end
                FROM_W: if (mul_done) result <= mul_result;
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_mont_exp_sequencer.sv
// Bench for mont_exp_sequencer: W=8 directed runs with a per-cycle model check,
// plus a W=1024 smoke run against a modular-exponentiation reference.
module tb_mont_exp_sequencer;

    typedef logic [1023:0] big_t;

    localparam int W   = 8;
    localparam int LW  = 4;
    localparam int L   = 4;
    localparam int BW  = 1024;
    localparam int BLW = 11;
    localparam int BL  = 1;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic          reset, start;
    logic [W-1:0]  in_x, in_e, in_m, in_r, in_r2;
    logic [LW-1:0] in_elen;
    logic          busy, done, mul_start, mul_done;
    logic [W-1:0]  result, mul_a, mul_b, mul_m, mul_result;

    logic           b_start;
    logic [BW-1:0]  b_in_x, b_in_e, b_in_m, b_in_r, b_in_r2;
    logic [BLW-1:0] b_in_elen;
    logic           b_busy, b_done, b_mul_start, b_mul_done;
    logic [BW-1:0]  b_result, b_mul_a, b_mul_b, b_mul_m, b_mul_result;

    mont_exp_sequencer #(.W(W), .LW(LW)) dut (
        .clk(clk), .reset(reset), .start(start),
        .in_x(in_x), .in_e(in_e), .in_elen(in_elen), .in_m(in_m), .in_r(in_r), .in_r2(in_r2),
        .busy(busy), .done(done), .result(result),
        .mul_start(mul_start), .mul_a(mul_a), .mul_b(mul_b), .mul_m(mul_m),
        .mul_result(mul_result), .mul_done(mul_done)
    );

    mont_exp_sequencer #(.W(BW), .LW(BLW)) dut_big (
        .clk(clk), .reset(reset), .start(b_start),
        .in_x(b_in_x), .in_e(b_in_e), .in_elen(b_in_elen), .in_m(b_in_m), .in_r(b_in_r), .in_r2(b_in_r2),
        .busy(b_busy), .done(b_done), .result(b_result),
        .mul_start(b_mul_start), .mul_a(b_mul_a), .mul_b(b_mul_b), .mul_m(b_mul_m),
        .mul_result(b_mul_result), .mul_done(b_mul_done)
    );

    int n_chk  = 0;
    int n_pass = 0;
    int cyc    = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input big_t got, input big_t exp);
        n_chk++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, got, exp, cyc);
    endtask

    // Montgomery product a*b*2^-w mod m by bitwise reduction.
    function automatic big_t mont(input big_t a, input big_t b, input big_t m, input int w);
        logic [2049:0] t, mm;
        mm = {1026'b0, m};
        t  = {1026'b0, a} * {1026'b0, b};
        for (int i = 0; i < w; i++) begin
            if (t[0]) t = t + mm;
            t = t >> 1;
        end
        if (t >= mm) t = t - mm;
        return t[1023:0];
    endfunction

    function automatic big_t modmul(input big_t a, input big_t b, input big_t m);
        logic [2047:0] p;
        p = {1024'b0, a} * {1024'b0, b};
        return big_t'(p % {1024'b0, m});
    endfunction

    function automatic big_t modexp(input big_t x, input big_t e, input int el, input big_t m);
        big_t r;
        r = big_t'(1);
        for (int i = el - 1; i >= 0; i--) begin
            r = modmul(r, r, m);
            if (e[i]) r = modmul(r, x, m);
        end
        return r;
    endfunction

    // Behavioural multipliers: mul_done arrives a fixed number of cycles after start.
    logic         rsp_pend = 1'b0, rsp_done = 1'b0, inj_done = 1'b0;
    int           rsp_due;
    logic [W-1:0] rsp_a, rsp_b, rsp_val = '0, inj_val = '0;
    assign mul_done   = rsp_done | inj_done;
    assign mul_result = inj_done ? inj_val : rsp_val;

    always @(negedge clk) begin
        rsp_done = 1'b0;
        if (rsp_pend && cyc == rsp_due) begin
            rsp_done = 1'b1;
            rsp_val  = W'(mont(big_t'(rsp_a), big_t'(rsp_b), big_t'(in_m), W));
            rsp_pend = 1'b0;
        end
        if (mul_start) begin
            rsp_a    = mul_a;
            rsp_b    = mul_b;
            rsp_due  = cyc + L;
            rsp_pend = 1'b1;
        end
    end

    logic          b_pend = 1'b0, b_rdone = 1'b0;
    int            b_due;
    logic [BW-1:0] b_ra, b_rb, b_rval = '0;
    assign b_mul_done   = b_rdone;
    assign b_mul_result = b_rval;

    always @(negedge clk) begin
        b_rdone = 1'b0;
        if (b_pend && cyc == b_due) begin
            b_rdone = 1'b1;
            b_rval  = mont(b_ra, b_rb, b_in_m, BW);
            b_pend  = 1'b0;
        end
        if (b_mul_start) begin
            b_ra   = b_mul_a;
            b_rb   = b_mul_b;
            b_due  = cyc + BL;
            b_pend = 1'b1;
        end
    end

    // Model of one run: start sampled in cycle c0, done expected in cycle edc.
    logic         act = 1'b0;
    int           c0 = 0, edc = 0, exp_n = 0, nst = 0;
    logic [W-1:0] exp_res = '0;

    always begin
        @(posedge clk);
        #2;
        if (!reset) begin
            if (act && mul_start) nst++;
            chk("busy", big_t'(busy), big_t'(act && cyc > c0 && cyc <= edc));
            chk("done", big_t'(done), big_t'(act && cyc == edc));
            chk("mul_m", big_t'(mul_m), big_t'(in_m));
            if (act && rsp_pend) begin
                chk("op_a_stable", big_t'(mul_a), big_t'(rsp_a));
                chk("op_b_stable", big_t'(mul_b), big_t'(rsp_b));
            end
            if (act && nst == exp_n && cyc < edc)
                chk("from_b_one", big_t'(mul_b), big_t'(1));
            if (act && cyc == edc) begin
                chk("model_result", big_t'(result), big_t'(exp_res));
                chk("mul_count", big_t'(nst), big_t'(exp_n));
            end
        end
    end

    task automatic begin_run(input int x, input int e, input int el, input int er, input int lat);
        int es, pc;
        @(negedge clk);
        in_x    = W'(x);
        in_e    = W'(e);
        in_elen = LW'(el);
        start   = 1'b1;
        es = (el > W) ? W : el;
        pc = 0;
        for (int i = 0; i < es; i++) pc += (e >> i) & 1;
        exp_n   = 2 + es + pc;
        c0      = cyc;
        edc     = cyc + exp_n * (L + 1) + 1;
        nst     = 0;
        exp_res = W'(modexp(big_t'(x), big_t'(e), es, big_t'(in_m)));
        act     = 1'b1;
        chk("model_lat_pin", big_t'(exp_n * (L + 1) + 1), big_t'(lat));
        chk("model_res_pin", big_t'(exp_res), big_t'(er));
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic run(input int x, input int e, input int el, input int er, input int lat,
                       input bit poke, input bit inj);
        int got;
        got = 0;
        begin_run(x, e, el, er, lat);
        if (inj) begin
            // TOM_I cycle: a done pulse alongside mul_start must not be captured
            inj_val  = 8'hAB;
            inj_done = 1'b1;
            @(negedge clk);
            inj_done = 1'b0;
        end
        for (int i = 0; i < lat + 20; i++) begin
            if (done) begin
                got   = cyc - c0;
                start = 1'b0;
                break;
            end
            start = poke && (i % 7 == 3);
            @(negedge clk);
        end
        start = 1'b0;
        chk("latency", big_t'(got), big_t'(lat));
        chk("result", big_t'(result), big_t'(er));
        repeat (3) @(negedge clk);
        chk("result_held", big_t'(result), big_t'(er));
    endtask

    initial begin
        logic [2048:0] pw;
        int            got;
        reset = 1'b1; start = 1'b0;
        in_x = '0; in_e = '0; in_elen = '0;
        in_m = 8'd13; in_r = 8'd9; in_r2 = 8'd3;
        b_start = 1'b0; b_in_x = '0; b_in_e = '0; b_in_elen = '0;
        b_in_m = '0; b_in_r = '0; b_in_r2 = '0;
        repeat (3) @(negedge clk);
        chk("rst_busy", big_t'(busy), big_t'(0));
        chk("rst_done", big_t'(done), big_t'(0));
        chk("rst_mul_start", big_t'(mul_start), big_t'(0));
        chk("rst_result", big_t'(result), big_t'(0));
        chk("rst_mul_a", big_t'(mul_a), big_t'(0));
        reset = 1'b0;

        run(2, 5, 3, 6, 36, 1'b0, 1'b0);
        run(7, 8'hFF, 8, 5, 91, 1'b1, 1'b0);
        run(7, 8'h05, 8, 11, 61, 1'b0, 1'b0);
        run(9, 123, 0, 1, 11, 1'b0, 1'b0);
        run(7, 8'hFF, 12, 5, 91, 1'b0, 1'b0);

        // Abort during the first square wait, then a stale done while idle.
        begin_run(7, 8'hFF, 8, 5, 91);
        repeat (7) @(negedge clk);
        reset = 1'b1;
        act   = 1'b0;
        @(negedge clk);
        reset = 1'b0;
        chk("abort_busy", big_t'(busy), big_t'(0));
        chk("abort_result", big_t'(result), big_t'(0));
        inj_val  = 8'h77;
        inj_done = 1'b1;
        @(negedge clk);
        inj_done = 1'b0;
        @(negedge clk);
        chk("stale_busy", big_t'(busy), big_t'(0));
        chk("stale_done", big_t'(done), big_t'(0));
        chk("stale_result", big_t'(result), big_t'(0));
        repeat (8) @(negedge clk);
        run(2, 5, 3, 6, 36, 1'b1, 1'b1);

        // Wide smoke run: random odd modulus, e = 65537.
        for (int i = 0; i < 32; i++) b_in_m[32*i +: 32] = $urandom;
        b_in_m[BW-1] = 1'b1;
        b_in_m[0]    = 1'b1;
        for (int i = 0; i < 32; i++) b_in_x[32*i +: 32] = $urandom;
        b_in_x  = modmul(b_in_x, big_t'(1), b_in_m);
        pw      = '0;
        pw[1024] = 1'b1;
        b_in_r  = big_t'(pw % {1025'b0, b_in_m});
        b_in_r2 = modmul(b_in_r, b_in_r, b_in_m);
        b_in_e  = big_t'(65537);
        b_in_elen = 11'd17;
        @(negedge clk);
        b_start = 1'b1;
        c0 = cyc;
        @(negedge clk);
        b_start = 1'b0;
        got = 0;
        for (int i = 0; i < 200; i++) begin
            if (b_done) begin
                got = cyc - c0;
                chk("big_busy_at_done", big_t'(b_busy), big_t'(1));
                break;
            end
            @(negedge clk);
        end
        chk("big_latency", big_t'(got), big_t'(21 * (BL + 1) + 1));
        chk("big_result", b_result, modexp(b_in_x, b_in_e, 17, b_in_m));
        chk("big_mul_m", b_mul_m, b_in_m);
        @(negedge clk);
        chk("big_idle", big_t'(b_busy), big_t'(0));

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end

endmodule
